// File: rtl/dibit_serializer_pkg.sv
// Shared types, default widths and the symbol-count helper for dibit_serializer.
package dibit_serializer_pkg;

    typedef enum logic {S_IDLE, S_SHIFT} ser_state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_SYM_W  = 2;

    function automatic int nsym(input int data_w, input int sym_w);
        return data_w / sym_w;
    endfunction

endpackage

// File: rtl/dibit_serializer.sv
// Splits a DATA_W-bit word into NSYM symbols of SYM_W bits, MSB field first,
// with valid/ready on both sides and zero-bubble back-to-back word handoff.
module dibit_serializer
    import dibit_serializer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SYM_W  = DEF_SYM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SYM_W-1:0]  out_sym,
    output logic              out_first,
    output logic              out_last
);

    localparam int NSYM  = nsym(DATA_W, SYM_W);
    localparam int CNT_W = (NSYM > 2) ? $clog2(NSYM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSYM - 1);
    localparam logic [CNT_W-1:0] CNT_PENU = CNT_W'(NSYM - 2);

    generate
        if ((DATA_W % SYM_W) != 0 || NSYM < 2) begin : g_bad_params
            $error("dibit_serializer: DATA_W must be a multiple of SYM_W with NSYM >= 2");
        end
    endgenerate

    ser_state_e        state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              take;
    logic              accept;

    // The last symbol leaving frees the holding register in the same cycle.
    assign take     = out_valid && out_ready;
    assign in_ready = !rst && (state == S_IDLE || (take && out_last));
    assign accept   = in_valid && in_ready;
    assign out_sym  = shreg[DATA_W-1 -: SYM_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_SHIFT;
                        shreg     <= in_data;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        out_first <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (take) begin
                        if (!out_last) begin
                            shreg     <= shreg << SYM_W;
                            cnt       <= cnt + CNT_W'(1);
                            out_first <= 1'b0;
                            out_last  <= (cnt == CNT_PENU);
                        end else if (accept) begin
                            shreg     <= in_data;
                            cnt       <= '0;
                            out_first <= 1'b1;
                            out_last  <= 1'b0;
                        end else begin
                            state     <= S_IDLE;
                            shreg     <= '0;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            out_first <= 1'b0;
                            out_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // cnt duplicates out_last for the hold path; keep it visible for debug.
    logic cnt_at_last;
    assign cnt_at_last = (cnt == CNT_LAST);
    logic unused_ok;
    assign unused_ok = cnt_at_last;

endmodule

// File: tb/tb_dibit_serializer.sv
// Directed-vector bench for dibit_serializer: default 8/2 instance plus a 6/3 instance.
module tb_dibit_serializer;
    import dibit_serializer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_first, out_last;
    logic [7:0] in_data;
    logic [1:0] out_sym;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_first, a_out_last;
    logic [5:0] a_in_data;
    logic [2:0] a_out_sym;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dibit_serializer #(.DATA_W(8), .SYM_W(2)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
        .out_first(out_first), .out_last(out_last)
    );

    dibit_serializer #(.DATA_W(6), .SYM_W(3)) u_alt (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sym(a_out_sym),
        .out_first(a_out_first), .out_last(a_out_last)
    );

    // {out_valid, out_first, out_last, out_sym}
    logic [4:0] obs;
    assign obs = {out_valid, out_first, out_last, out_sym};

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_data = 6'h2A; a_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (obs !== 5'b0) begin
            miscompares++; $display("FAIL reset_outputs: got %b want %b", obs, 5'b0);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        vectors++;
        if ({a_out_valid, a_out_first, a_out_last, a_out_sym, a_in_ready} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_alt: got %b want 0", {a_out_valid, a_out_first, a_out_last, a_out_sym, a_in_ready});
        end
        in_valid = 1'b0; a_in_valid = 1'b0;
    endtask

    task automatic test_unaccepted;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'hFF;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({obs, in_ready} !== 6'b000001) begin
            miscompares++; $display("FAIL unaccepted_idle: got %b want 000001", {obs, in_ready});
        end
    endtask

    task automatic test_single;
        logic [1:0] syms [4];
        logic [4:0] exp;
        syms = '{2'b10, 2'b11, 2'b01, 2'b00};
        in_valid = 1'b1; in_data = 8'hB4; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL single_ready_idle: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp = {1'b1, i == 0, i == 3, syms[i]};
            vectors++;
            if (obs !== exp) begin
                miscompares++; $display("FAIL single_sym%0d: got %b want %b", i, obs, exp);
            end
            vectors++;
            if (in_ready !== (i == 3)) begin
                miscompares++; $display("FAIL single_ready%0d: got %b want %b", i, in_ready, i == 3);
            end
            @(negedge clk);
        end
        #1;
        vectors++;
        if ({obs, in_ready} !== 6'b000001) begin
            miscompares++; $display("FAIL single_idle_after: got %b want 000001", {obs, in_ready});
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] syms [8];
        logic [4:0] exp;
        syms = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
        in_valid = 1'b1; in_data = 8'hB4; out_ready = 1'b1;
        @(negedge clk);
        in_data = 8'h1E;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) in_valid = 1'b0;
            #1;
            exp = {1'b1, i == 0 || i == 4, i == 3 || i == 7, syms[i]};
            vectors++;
            if (obs !== exp) begin
                miscompares++; $display("FAIL b2b_sym%0d: got %b want %b", i, obs, exp);
            end
            vectors++;
            if (in_ready !== (i == 3 || i == 7)) begin
                miscompares++; $display("FAIL b2b_ready%0d: got %b want %b", i, in_ready, i == 3 || i == 7);
            end
            @(negedge clk);
        end
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle_after: got %b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        in_valid = 1'b1; in_data = 8'hB4; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (obs !== 5'b11010) begin
            miscompares++; $display("FAIL bp_sym0: got %b want 11010", obs);
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) out_ready = 1'b1;
            #1;
            vectors++;
            if ({obs, in_ready} !== 6'b100110) begin
                miscompares++; $display("FAIL bp_hold%0d: got %b want 100110", k, {obs, in_ready});
            end
            @(negedge clk);
        end
        #1;
        vectors++;
        if ({obs, in_ready} !== 6'b100010) begin
            miscompares++; $display("FAIL bp_sym2: got %b want 100010", {obs, in_ready});
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({obs, in_ready} !== 6'b101001) begin
            miscompares++; $display("FAIL bp_sym3: got %b want 101001", {obs, in_ready});
        end
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_idle_after: got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_word;
        logic [1:0] syms [4];
        logic [4:0] exp;
        syms = '{2'b00, 2'b00, 2'b11, 2'b11};
        in_valid = 1'b1; in_data = 8'hB4; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (obs !== 5'b10011) begin
            miscompares++; $display("FAIL rstmid_sym1: got %b want 10011", obs);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_ready_in_rst: got %b want 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({obs, in_ready} !== 6'b000001) begin
            miscompares++; $display("FAIL rstmid_cleared: got %b want 000001", {obs, in_ready});
        end
        in_valid = 1'b1; in_data = 8'h0F;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp = {1'b1, i == 0, i == 3, syms[i]};
            vectors++;
            if (obs !== exp) begin
                miscompares++; $display("FAIL rstmid_next_sym%0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alt_params;
        a_in_valid = 1'b1; a_in_data = 6'b101101; a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0; a_in_data = 6'b000000;
        #1;
        vectors++;
        if ({a_out_valid, a_out_first, a_out_last, a_out_sym} !== 6'b110101) begin
            miscompares++;
            $display("FAIL alt_sym0: got %b want 110101", {a_out_valid, a_out_first, a_out_last, a_out_sym});
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({a_out_valid, a_out_first, a_out_last, a_out_sym} !== 6'b101101) begin
            miscompares++;
            $display("FAIL alt_sym1: got %b want 101101", {a_out_valid, a_out_first, a_out_last, a_out_sym});
        end
        @(negedge clk);
        #1;
        vectors++;
        if (a_out_valid !== 1'b0) begin
            miscompares++; $display("FAIL alt_idle_after: got %b want 0", a_out_valid);
        end
    endtask

    initial begin
        test_reset;
        test_unaccepted;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_reset_mid_word;
        test_alt_params;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
